// File: rtl/kalman_1d_if.sv
// Measurement-in / estimate-out bundle of the 1-D Kalman filter.
// The producer/consumer side uses the master modport, the filter the slave.
interface kalman_1d_if;
    logic signed [31:0] z;
    logic               z_valid;
    logic               z_ready;
    logic signed [31:0] xf;
    logic               xf_valid;
    logic signed [31:0] p_cov;

    modport master (
        output z,
        output z_valid,
        input  z_ready,
        input  xf,
        input  xf_valid,
        input  p_cov
    );

    modport slave (
        input  z,
        input  z_valid,
        output z_ready,
        output xf,
        output xf_valid,
        output p_cov
    );
endinterface

// File: rtl/kalman_1d.sv
// Scalar Kalman filter in signed Q4.28 fixed point.
// One measurement per 32 cycles: predict, 28-cycle restoring divide for the
// gain, then state and covariance updates. All arithmetic saturates.
module kalman_1d #(
    parameter logic signed [31:0] Q_NOISE = 32'sh0100_0000,
    parameter logic signed [31:0] R_NOISE = 32'sh1000_0000,
    parameter logic signed [31:0] P_INIT  = 32'sh1000_0000,
    parameter logic signed [31:0] X_INIT  = 32'sh0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    kalman_1d_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PREDICT = 3'd1,
        ST_DIV     = 3'd2,
        ST_UPD_X   = 3'd3,
        ST_UPD_P   = 3'd4
    } state_t;

    // Clamp a 33-bit intermediate into the 32-bit signed range.
    function automatic logic signed [31:0] sat33(input logic signed [32:0] v);
        if (v[32] != v[31]) begin
            return v[32] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
        end else begin
            return v[31:0];
        end
    endfunction

    function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                   input logic signed [31:0] b);
        return sat33({a[31], a} + {b[31], b});
    endfunction

    function automatic logic signed [31:0] sat_sub(input logic signed [31:0] a,
                                                   input logic signed [31:0] b);
        return sat33({a[31], a} - {b[31], b});
    endfunction

    // Q4.28 multiply: full product, arithmetic shift (floor), saturate.
    function automatic logic signed [31:0] qmul(input logic signed [31:0] a,
                                                input logic signed [31:0] b);
        logic signed [63:0] prod;
        logic signed [63:0] shifted;
        prod    = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        shifted = prod >>> 28;
        if (shifted[63:31] != {33{shifted[31]}}) begin
            return shifted[63] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
        end else begin
            return shifted[31:0];
        end
    endfunction

    state_t             state_q, state_d;
    logic               z_ready_q;
    logic signed [31:0] x_q, x_d;
    logic signed [31:0] p_q, p_d;
    logic signed [31:0] pp_q, pp_d;
    logic signed [31:0] s_q, s_d;
    logic signed [31:0] z_q, z_d;
    logic        [31:0] rem_q, rem_d;
    logic        [27:0] quo_q, quo_d;
    logic        [4:0]  cnt_q, cnt_d;
    logic signed [31:0] xf_q, xf_d;
    logic               xf_valid_q, xf_valid_d;

    logic               accept;
    logic signed [31:0] pp_pred;
    logic signed [31:0] s_pred;
    logic signed [31:0] k_gain;
    logic        [32:0] rem_sh;
    logic signed [31:0] x_upd;
    logic signed [31:0] p_raw;
    logic signed [31:0] p_upd;

    assign accept  = bus.z_valid && z_ready_q;
    assign pp_pred = sat_add(p_q, Q_NOISE);
    assign s_pred  = sat_add(pp_pred, R_NOISE);
    // Gain has no integer bits, so the quotient sits in the fraction field.
    assign k_gain  = {4'b0000, quo_q};
    assign rem_sh  = {rem_q, 1'b0};
    assign x_upd   = sat_add(x_q, qmul(k_gain, sat_sub(z_q, x_q)));
    assign p_raw   = sat_sub(pp_q, qmul(k_gain, pp_q));
    assign p_upd   = p_raw[31] ? 32'sh0000_0000 : p_raw;

    // State register; ready is registered from the next state so it tracks IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            z_ready_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            z_ready_q <= (state_d == ST_IDLE);
        end
    end

    // Sequencing: accept, one predict cycle, 28 divide steps, two update cycles.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_PREDICT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PREDICT: state_d = ST_DIV;
            ST_DIV: begin
                if (cnt_q == 5'd27) begin
                    state_d = ST_UPD_X;
                end else begin
                    state_d = ST_DIV;
                end
            end
            ST_UPD_X: state_d = ST_UPD_P;
            ST_UPD_P: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Datapath registers; reset also discards any update in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q        <= X_INIT;
            p_q        <= P_INIT;
            pp_q       <= 32'sh0000_0000;
            s_q        <= 32'sh0000_0000;
            z_q        <= 32'sh0000_0000;
            rem_q      <= 32'd0;
            quo_q      <= 28'd0;
            cnt_q      <= 5'd0;
            xf_q       <= X_INIT;
            xf_valid_q <= 1'b0;
        end else begin
            x_q        <= x_d;
            p_q        <= p_d;
            pp_q       <= pp_d;
            s_q        <= s_d;
            z_q        <= z_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            cnt_q      <= cnt_d;
            xf_q       <= xf_d;
            xf_valid_q <= xf_valid_d;
        end
    end

    // Per-state datapath work; everything holds unless its state updates it.
    always_comb begin
        x_d        = x_q;
        p_d        = p_q;
        pp_d       = pp_q;
        s_d        = s_q;
        z_d        = z_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        cnt_d      = cnt_q;
        xf_d       = xf_q;
        xf_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    z_d = bus.z;
                end else begin
                    z_d = z_q;
                end
            end
            ST_PREDICT: begin
                pp_d  = pp_pred;
                s_d   = s_pred;
                rem_d = pp_pred;
                quo_d = 28'd0;
                cnt_d = 5'd0;
            end
            ST_DIV: begin
                // Remainder stays below S, so the shifted value fits 33 bits.
                if (rem_sh >= {1'b0, s_q}) begin
                    rem_d = rem_sh[31:0] - s_q;
                    quo_d = {quo_q[26:0], 1'b1};
                end else begin
                    rem_d = rem_sh[31:0];
                    quo_d = {quo_q[26:0], 1'b0};
                end
                cnt_d = cnt_q + 5'd1;
            end
            ST_UPD_X: begin
                x_d = x_upd;
            end
            ST_UPD_P: begin
                p_d        = p_upd;
                xf_d       = x_q;
                xf_valid_d = 1'b1;
            end
            default: begin
                xf_valid_d = 1'b0;
            end
        endcase
    end

    assign bus.z_ready  = z_ready_q;
    assign bus.xf       = xf_q;
    assign bus.xf_valid = xf_valid_q;
    assign bus.p_cov    = p_q;

endmodule

// File: tb/tb_kalman_1d.sv
// Directed bench for kalman_1d: three instances (defaults, saturating
// initial state, zero noise) share clock, reset and measurement stimulus.
module tb_kalman_1d;

    localparam logic signed [31:0] Q_DEF = 32'sh0100_0000;
    localparam logic signed [31:0] R_DEF = 32'sh1000_0000;
    localparam logic signed [31:0] P_DEF = 32'sh1000_0000;
    localparam logic signed [31:0] ONE   = 32'sh1000_0000;
    localparam logic signed [31:0] HALF  = 32'sh0800_0000;
    localparam logic signed [31:0] NEG8  = 32'sh8000_0000;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [31:0] z_s;
    logic               z_valid_s;

    int n_tests = 0;
    int n_fail  = 0;

    int                 lat, nlow, cnt, viol, mm, nxfv;
    int                 acc_cyc[$];
    logic signed [31:0] xm, pm, prev;
    real                ideal, a_ss, pss;

    always #5 clk = ~clk;

    kalman_1d_if if0 ();
    kalman_1d_if if1 ();
    kalman_1d_if if2 ();

    assign if0.z = z_s;  assign if0.z_valid = z_valid_s;
    assign if1.z = z_s;  assign if1.z_valid = z_valid_s;
    assign if2.z = z_s;  assign if2.z_valid = z_valid_s;

    kalman_1d dut0 (.clk(clk), .rst(rst), .bus(if0));
    kalman_1d #(.X_INIT(32'sh7F00_0000)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    kalman_1d #(.Q_NOISE(32'sh0000_0000), .P_INIT(32'sh0000_0000))
        dut2 (.clk(clk), .rst(rst), .bus(if2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic real r_abs(input real v);
        return (v < 0.0) ? -v : v;
    endfunction

    // Reference arithmetic using wide integers and a true division.
    function automatic logic signed [31:0] m_sat(input longint v);
        logic signed [63:0] t;
        t = v;
        if (v > 64'sd2147483647)  return 32'sh7FFF_FFFF;
        if (v < -64'sd2147483648) return 32'sh8000_0000;
        return t[31:0];
    endfunction

    function automatic logic signed [31:0] m_qmul(input logic signed [31:0] a,
                                                  input logic signed [31:0] b);
        longint p;
        p = longint'(a) * longint'(b);
        return m_sat(p >>> 28);
    endfunction

    task automatic m_step(inout logic signed [31:0] x, inout logic signed [31:0] p,
                          input logic signed [31:0] zv, input logic signed [31:0] q,
                          input logic signed [31:0] r);
        logic signed [31:0] pp, s, k, d, pn;
        longint num;
        pp  = m_sat(longint'(p) + longint'(q));
        s   = m_sat(longint'(pp) + longint'(r));
        num = longint'(pp) <<< 28;
        k   = m_sat(num / longint'(s));
        d   = m_sat(longint'(zv) - longint'(x));
        x   = m_sat(longint'(x) + longint'(m_qmul(k, d)));
        pn  = m_sat(longint'(pp) - longint'(m_qmul(k, pp)));
        p   = (pn < 0) ? 32'sh0000_0000 : pn;
    endtask

    function automatic logic signed [31:0] zval(input int i);
        return 32'(i) * 32'sh0040_0000 - 32'sh0C00_0000;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Offer one sample, wait for the result; returns cycles to xf_valid and
    // the number of sampled cycles with z_ready low in between.
    task automatic send(input logic signed [31:0] zv, output int l, output int nl);
        int w;
        z_s       = zv;
        z_valid_s = 1'b1;
        w = 0;
        while (!if0.z_ready && w < 64) begin
            @(negedge clk);
            w++;
        end
        chk("ready_wait", 32'(if0.z_ready), 32'd1);
        @(negedge clk);
        z_valid_s = 1'b0;
        l  = 0;
        nl = 0;
        for (int n = 0; n <= 40; n++) begin
            if (if0.xf_valid) begin
                l = n;
                break;
            end
            if (!if0.z_ready) nl++;
            @(negedge clk);
        end
    endtask

    initial begin
        rst       = 1'b1;
        z_s       = 32'sh0000_0000;
        z_valid_s = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_xf",        if0.xf,              32'h0000_0000);
        chk("rst_pcov",      if0.p_cov,           32'h1000_0000);
        chk("rst_xfv",       32'(if0.xf_valid),   32'd0);
        chk("rst_ready",     32'(if0.z_ready),    32'd1);
        chk("rst_xf_sat",    if1.xf,              32'h7F00_0000);
        chk("rst_pcov_zero", if2.p_cov,           32'h0000_0000);
        @(negedge clk);
        rst = 1'b0;

        // First sample z = 1.0
        ideal = 268435456.0 * 17.0 / 33.0;
        send(ONE, lat, nlow);
        chk("first_lat",      32'(lat),  32'd31);
        chk("first_readylow", 32'(nlow), 32'd31);
        chk("first_xf",       if0.xf,    32'h083E_0F83);
        chk("first_pcov",     if0.p_cov, 32'h083E_0F85);
        chk("first_xf_tol",   32'(r_abs(real'(if0.xf) - ideal) <= 4.0),    32'd1);
        chk("first_p_tol",    32'(r_abs(real'(if0.p_cov) - ideal) <= 4.0), 32'd1);
        chk("first_ready",    32'(if0.z_ready), 32'd1);
        chk("zero_xf_a",      if2.xf,    32'h0000_0000);
        chk("zero_p_a",       if2.p_cov, 32'h0000_0000);
        @(negedge clk);
        chk("xfv_pulse",      32'(if0.xf_valid), 32'd0);
        chk("xf_hold",        if0.xf,    32'h083E_0F83);
        chk("pcov_hold",      if0.p_cov, 32'h083E_0F85);

        // Abort during the divide, then a clean repeat of the first sample
        do_reset();
        z_s       = ONE;
        z_valid_s = 1'b1;
        chk("abort_ready_pre", 32'(if0.z_ready), 32'd1);
        @(negedge clk);
        z_valid_s = 1'b0;
        repeat (10) @(negedge clk);
        chk("abort_busy", 32'(if0.z_ready), 32'd0);
        rst = 1'b1;
        #1;
        chk("abort_ready_rst", 32'(if0.z_ready), 32'd1);
        chk("abort_xf_rst",    if0.xf,    32'h0000_0000);
        chk("abort_p_rst",     if0.p_cov, 32'h1000_0000);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        for (int n = 0; n < 40; n++) begin
            if (if0.xf_valid) cnt++;
            @(negedge clk);
        end
        chk("abort_no_xfv", 32'(cnt), 32'd0);
        send(ONE, lat, nlow);
        chk("abort_lat",  32'(lat),  32'd31);
        chk("abort_xf",   if0.xf,    32'h083E_0F83);
        chk("abort_pcov", if0.p_cov, 32'h083E_0F85);

        // z_valid held for 100 cycles with a changing measurement
        do_reset();
        acc_cyc.delete();
        nxfv = 0;
        for (int i = 0; i < 100; i++) begin
            z_s       = zval(i);
            z_valid_s = 1'b1;
            if (if0.xf_valid) nxfv++;
            if (if0.z_ready) acc_cyc.push_back(i);
            @(negedge clk);
        end
        if (if0.xf_valid) nxfv++;
        z_valid_s = 1'b0;
        chk("thr_n_acc", 32'(acc_cyc.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            chk("thr_acc_cyc", (k < acc_cyc.size()) ? 32'(acc_cyc[k]) : 32'hFFFF_FFFF, 32'(k * 32));
        end
        chk("thr_xfv", 32'(nxfv), 32'd3);
        xm = 32'sh0000_0000;
        pm = P_DEF;
        for (int k = 0; k < 3; k++) m_step(xm, pm, zval(k * 32), Q_DEF, R_DEF);
        chk("thr_xf3", if0.xf,    xm);
        chk("thr_p3",  if0.p_cov, pm);
        cnt = 0;
        while (!if0.xf_valid && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        m_step(xm, pm, zval(96), Q_DEF, R_DEF);
        chk("thr_xf4", if0.xf,    xm);
        chk("thr_p4",  if0.p_cov, pm);

        // Constant z = 0.5 for 200 samples
        do_reset();
        xm   = 32'sh0000_0000;
        pm   = P_DEF;
        prev = P_DEF;
        viol = 0;
        mm   = 0;
        for (int s = 0; s < 200; s++) begin
            send(HALF, lat, nlow);
            m_step(xm, pm, HALF, Q_DEF, R_DEF);
            if (if0.xf !== xm || if0.p_cov !== pm || lat != 31) mm++;
            if (s >= 2 && if0.p_cov > prev) viol++;
            prev = if0.p_cov;
        end
        a_ss = (0.0625 + $sqrt(0.0625 * 0.0625 + 4.0 * 0.0625 * 1.0)) / 2.0;
        pss  = a_ss - 0.0625;
        chk("conv_model_mm", 32'(mm),   32'd0);
        chk("conv_p_mono",   32'(viol), 32'd0);
        chk("conv_xf",       if0.xf,    xm);
        chk("conv_p",        if0.p_cov, pm);
        chk("conv_xf_tol",   32'(r_abs(real'(if0.xf - HALF)) < 65536.0), 32'd1);
        chk("conv_p_ss",     32'(r_abs(real'(if0.p_cov) / 268435456.0 - pss) < 1.0 / 1048576.0), 32'd1);
        chk("zero_xf_c",     if2.xf,    32'h0000_0000);
        chk("zero_p_c",      if2.p_cov, 32'h0000_0000);

        // Saturating innovation from a large positive initial state
        do_reset();
        xm   = 32'sh7F00_0000;
        pm   = P_DEF;
        prev = 32'sh7F00_0000;
        for (int s = 0; s < 5; s++) begin
            send(NEG8, lat, nlow);
            m_step(xm, pm, NEG8, Q_DEF, R_DEF);
            if (s == 0) begin
                chk("sat_xf1", if1.xf, 32'h3D0F_83E8);
                chk("neg_xf1", if0.xf, 32'hBE0F_83E8);
            end
            chk("sat_xf",      if1.xf,                  xm);
            chk("sat_dec",     32'(if1.xf < prev),      32'd1);
            chk("sat_p_nneg",  32'(if1.p_cov[31]),      32'd0);
            chk("zero_xf_e",   if2.xf,                  32'h0000_0000);
            chk("zero_p_e",    if2.p_cov,               32'h0000_0000);
            prev = if1.xf;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/kalman_1d.md
KALMAN_1D -- requirements
Module: kalman_1d

Interface
REQ-001 Parameters SHALL be (name, default, meaning), all signed Q4.28:
  Q_NOISE, 32'sh0100_0000 (0.0625), process-noise variance added at every predict step; SHALL be >= 0.
  R_NOISE, 32'sh1000_0000 (1.0), measurement-noise variance; SHALL be > 0.
  P_INIT, 32'sh1000_0000 (1.0), error covariance after reset; SHALL be >= 0.
  X_INIT, 32'sh0000_0000 (0.0), state estimate after reset.
REQ-002 Ports SHALL be (name, direction, width, meaning):
  clk  input  1  single clock; all state updates on rising edge.
  rst  input  1  reset, asynchronous, active-high.
  z  input  32  signed Q4.28 measurement.
  z_valid  input  1  z is valid this cycle.
  z_ready  output  1  block can accept a measurement.
  xf  output  32  signed Q4.28 filtered estimate; feeds the controller's xf input.
  xf_valid  output  1  one-cycle pulse when xf has been updated.
  p_cov  output  32  signed Q4.28 current error covariance, for debug.

Function
REQ-003 A measurement SHALL be accepted on a rising edge where z_valid && z_ready; z SHALL be captured into an internal register on that edge.
REQ-004 The FSM SHALL have states IDLE, PREDICT, DIV, UPD_X, UPD_P; z_ready SHALL be 1 only in IDLE.
REQ-005 IDLE -> PREDICT on acceptance; otherwise stay in IDLE.
REQ-006 PREDICT (1 cycle) SHALL compute Pp = sat(P + Q_NOISE) and S = sat(Pp + R_NOISE), then go to DIV.
REQ-007 DIV SHALL run a restoring fractional divide K = Pp/S for exactly 28 cycles, producing one quotient bit per cycle, MSB first.
  Remainder starts at Pp; each step shifts left by 1, and subtracts S when remainder >= S (quotient bit = 1).
  K has integer part 0, so K is in [0,1).
REQ-008 UPD_X (1 cycle) SHALL set x = sat(x + qmul(K, sat(z_reg - x))).
REQ-009 UPD_P (1 cycle) SHALL set P = sat(Pp - qmul(K, Pp)), clamped to >= 0.
  On the same edge it SHALL load xf with the new x, assert xf_valid, and return to IDLE.
REQ-010 qmul SHALL be a full 64-bit signed product with result bits [59:28] (truncation toward minus infinity).
  Overflow SHALL saturate to 32'sh7FFF_FFFF / 32'sh8000_0000.
REQ-011 All adds and subtracts SHALL be computed in 33 bits and saturated to 32 bits; no wrap-around is permitted.
REQ-012 Latency SHALL be fixed: xf_valid is high in the cycle after the 31st rising edge following the acceptance edge.
  xf_valid SHALL be high for exactly 1 cycle.
  z_ready SHALL return to 1 in that same cycle.
  Maximum throughput SHALL be one sample per 32 cycles.
REQ-013 z_valid asserted while z_ready = 0 SHALL be ignored; no sample is queued.
  The producer holds z until it sees z_ready.
REQ-014 xf and p_cov SHALL hold their values between updates (registered outputs).

Reset
REQ-015 While rst = 1, and immediately on its assertion, the block SHALL set:
  FSM = IDLE, x = xf = X_INIT, P = p_cov = P_INIT.
  xf_valid = 0, z_ready = 1.
  Divider, remainder and quotient registers = 0.
REQ-016 Reset asserted in any non-IDLE state SHALL abort the update; the in-flight sample SHALL have no effect.
  After release, the next sample SHALL behave as the first sample after power-up.
REQ-017 The first acceptance after rst deasserts SHALL occur on the first rising edge with rst low and z_valid high.

Verification
REQ-018 Defaults; first sample z = 1.0 (32'sh1000_0000):
  xf_valid 31 edges later; xf ~= 0.515152, p_cov ~= 0.515152, each within 2^-26 of ideal.
  z_ready low for exactly 31 cycles.
REQ-019 Constant z = 0.5 (32'sh0800_0000) fed for 200 samples -> |xf - 0.5| < 2^-12.
  p_cov monotonically non-increasing after the 2nd sample and converged to within 2^-20 of its steady state.
REQ-020 rst pulsed during DIV (cycle 10 after acceptance), then z = 1.0 fed ->
  z_ready = 1 and xf = X_INIT during reset; no xf_valid for the aborted sample.
  Next result is identical to REQ-018.
REQ-021 z_valid held high continuously for 100 cycles with changing z -> exactly 4 samples accepted, on cycles 0, 32, 64, 96.
  xf_valid count = 3 by cycle 99; each z is consumed only when z_ready = 1.
REQ-022 Saturation: X_INIT = 32'sh7F00_0000, z = 32'sh8000_0000 -> z - x saturates to 32'sh8000_0000.
  xf moves negative monotonically with no sign wrap; p_cov stays >= 0.
REQ-023 Q_NOISE = 0 and P_INIT = 0 -> K = 0 and xf stays at X_INIT for any z; p_cov stays 0.
